// File: rtl/wb_mem_arbiter_pkg.sv
// mem_arb_pkg: shared state encoding, bus widths and timeout data for wb_mem_arbiter
package mem_arb_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;
  localparam int ADR_W = 30;
  localparam int DAT_W = 32;
  localparam int SEL_W = 4;
  localparam logic [DAT_W-1:0] TIMEOUT_DATA = 32'hFFFF_FFFF;
endpackage

// File: rtl/wb_mem_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first requester at or after ptr wins
module rr_pick #(
  parameter int NM = 2,
  parameter int PW = $clog2(NM)
) (
  input  logic [NM-1:0] req,
  input  logic [PW-1:0] ptr,
  output logic [NM-1:0] gnt
);
  // scan from farthest to nearest so the nearest requester after ptr overwrites last
  always_comb begin
    gnt = '0;
    for (int k = NM - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % NM]) gnt = NM'(1) << ((int'(ptr) + k) % NM);
  end
endmodule

// File: rtl/wb_mem_arbiter.sv
// wb_mem_arbiter: round-robin Wishbone arbiter for NM masters onto one memory slave; MEMARB_TIMEOUT_EN adds a stall watchdog
module wb_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NM      = 2,
  parameter int TIMEOUT = 1023,
  parameter int TW      = 10
) (
  input  logic                cpu_clk,
  input  logic                rst_n,
  input  logic [NM-1:0]       m_cyc_i,
  input  logic [NM-1:0]       m_stb_i,
  input  logic [NM-1:0]       m_we_i,
  input  logic [NM*ADR_W-1:0] m_adr_i,
  input  logic [NM*DAT_W-1:0] m_dat_i,
  input  logic [NM*SEL_W-1:0] m_sel_i,
  output logic [31:0]         m_dat_o,
  output logic [NM-1:0]       m_ack_o,
  output logic                s_cyc_o,
  output logic                s_stb_o,
  output logic                s_we_o,
  output logic [2:31]         s_adr_o,
  output logic [0:31]         s_dat_o,
  output logic [0:3]          s_sel_o,
  input  logic [0:31]         s_dat_i,
  input  logic                s_ack_i,
  output logic [NM-1:0]       grant_o,
  output logic                timeout_o
);
  localparam int PW = $clog2(NM);
  state_t state;
  logic [PW-1:0] ptr;
  logic [NM-1:0] req, pick;
  logic busy, fire;
  int g;
  assign req  = m_cyc_i & m_stb_i;
  assign busy = state == ST_BUSY;
  rr_pick #(.NM(NM), .PW(PW)) u_pick (.req(req), .ptr(ptr), .gnt(pick));
  // index of the granted master, 0 when no grant is held
  always_comb begin
    g = 0;
    for (int i = 0; i < NM; i++) if (grant_o[i]) g = i;
  end
`ifdef MEMARB_TIMEOUT_EN
  logic [TW-1:0] cnt;
  logic stall;
  assign stall = busy && m_cyc_i[g] && m_stb_i[g] && !s_ack_i;
  assign fire  = stall && cnt == TW'(TIMEOUT - 1);
  // stall counter and sticky watchdog flag
  always_ff @(posedge cpu_clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      timeout_o <= 1'b0;
    end else begin
      cnt       <= (!busy || s_ack_i || fire) ? '0 : cnt + TW'(stall);
      timeout_o <= timeout_o | fire;
    end
  end
`else
  assign fire      = 1'b0;
  assign timeout_o = 1'b0;
`endif
  // forward the granted master to the slave and route the ack back
  always_comb begin
    s_cyc_o    = busy & m_cyc_i[g];
    s_stb_o    = busy & m_stb_i[g] & ~fire;
    s_we_o     = m_we_i[g];
    s_adr_o    = m_adr_i[g*ADR_W +: ADR_W];
    s_dat_o    = m_dat_i[g*DAT_W +: DAT_W];
    s_sel_o    = m_sel_i[g*SEL_W +: SEL_W];
    m_ack_o    = '0;
    m_ack_o[g] = busy & ((s_ack_i & m_cyc_i[g] & m_stb_i[g]) | fire);
    m_dat_o    = fire ? TIMEOUT_DATA : s_dat_i;
  end
  // arbitration FSM: grant held until the owner drops cyc
  always_ff @(posedge cpu_clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      grant_o <= '0;
      ptr     <= '0;
    end else if (!busy) begin
      if (|req) begin
        grant_o <= pick;
        state   <= ST_BUSY;
      end
    end else if (!m_cyc_i[g]) begin
      grant_o <= '0;
      ptr     <= PW'((g + 1) % NM);
      state   <= ST_IDLE;
    end
  end
endmodule

// File: tb/tb_wb_mem_arbiter.sv
// tb_wb_mem_arbiter: directed plus randomized self-checking bench for wb_mem_arbiter
module tb_wb_mem_arbiter;
  localparam int NM = 3;
  logic clk = 0, rst_n = 0;
  logic [NM-1:0] m_cyc_i = '0, m_stb_i = '0, m_we_i = '0, m_ack_o, grant_o;
  logic [NM*30-1:0] m_adr_i;
  logic [NM*32-1:0] m_dat_i;
  logic [NM*4-1:0] m_sel_i;
  logic [31:0] m_dat_o;
  logic s_cyc_o, s_stb_o, s_we_o, timeout_o;
  logic s_ack_i = 0;
  logic [2:31] s_adr_o;
  logic [0:31] s_dat_o;
  logic [0:31] s_dat_i = '0;
  logic [0:3] s_sel_o;
  logic [29:0] adr [NM];
  logic [31:0] dat [NM];
  logic [3:0] sel [NM];
  int checks = 0, failures = 0, mptr = 0;
  always #5 clk = ~clk;
  always_comb
    for (int i = 0; i < NM; i++) begin
      m_adr_i[i*30 +: 30] = adr[i];
      m_dat_i[i*32 +: 32] = dat[i];
      m_sel_i[i*4 +: 4]   = sel[i];
    end
  wb_mem_arbiter #(.NM(NM), .TIMEOUT(8), .TW(4)) dut (
    .cpu_clk(clk), .rst_n(rst_n), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_dat_o(m_dat_o), .m_ack_o(m_ack_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
    .s_sel_o(s_sel_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .grant_o(grant_o), .timeout_o(timeout_o));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    mptr = 0;
    #1;
  endtask
  task automatic serve(input int m, input logic [31:0] rd, input int dly);
    int n;
    n = 0;
    while (!(s_stb_o && grant_o[m]) && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("grant_wait", 32'(n < 20), 1);
    chk("grant", 32'(grant_o), 32'(1) << m);
    chk("s_adr", 32'(s_adr_o), 32'(adr[m]));
    chk("s_we", 32'(s_we_o), 32'(m_we_i[m]));
    chk("s_sel", 32'(s_sel_o), 32'(sel[m]));
    if (m_we_i[m]) chk("s_dat", s_dat_o, dat[m]);
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      #1;
      chk("early_ack", 32'(m_ack_o), 0);
    end
    s_ack_i = 1;
    s_dat_i = rd;
    #1;
    chk("m_ack", 32'(m_ack_o), 32'(1) << m);
    chk("m_dat", m_dat_o, rd);
    @(negedge clk);
    s_ack_i = 0;
    m_cyc_i[m] = 0;
    m_stb_i[m] = 0;
    #1;
    chk("ack_drop", 32'(m_ack_o), 0);
    mptr = (m + 1) % NM;
  endtask
  initial begin
    logic [NM-1:0] rq;
    int m, n;
    for (int i = 0; i < NM; i++) begin
      adr[i] = '0;
      dat[i] = '0;
      sel[i] = '0;
    end
    do_reset();
    chk("rst_grant", 32'(grant_o), 0);
    chk("rst_cyc", 32'(s_cyc_o), 0);
    chk("rst_ack", 32'(m_ack_o), 0);
    chk("rst_timeout", 32'(timeout_o), 0);
    // single read by master 0, slave acks in the 5th cycle
    @(negedge clk);
    adr[0] = 30'h0000100;
    sel[0] = 4'hF;
    m_cyc_i[0] = 1;
    m_stb_i[0] = 1;
    #1;
    chk("lat_idle", 32'(s_stb_o), 0);
    @(negedge clk);
    #1;
    chk("lat_stb", 32'(s_stb_o), 1);
    serve(0, 32'h12345678, 4);
    @(negedge clk);
    #1;
    chk("idle_grant", 32'(grant_o), 0);
    // simultaneous requests from reset, then pointer wrap
    do_reset();
    @(negedge clk);
    m_cyc_i[1:0] = 2'b11;
    m_stb_i[1:0] = 2'b11;
    #1;
    serve(0, 32'h11, 1);
    serve(1, 32'h22, 0);
    @(negedge clk);
    m_cyc_i[1:0] = 2'b11;
    m_stb_i[1:0] = 2'b11;
    #1;
    serve(0, 32'h33, 0);
    serve(1, 32'h44, 2);
    // master 1 locked burst of three writes while master 0 waits
    @(negedge clk);
    adr[1] = 30'h0000200;
    sel[1] = 4'hF;
    dat[1] = 32'hA0;
    m_we_i[1] = 1;
    m_cyc_i[1] = 1;
    m_stb_i[1] = 1;
    n = 0;
    while (!grant_o[1] && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("burst_wait", 32'(n < 20), 1);
    m_we_i[0] = 0;
    adr[0] = 30'h0000300;
    m_cyc_i[0] = 1;
    m_stb_i[0] = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("burst_grant", 32'(grant_o), 32'b010);
      chk("burst_dat", s_dat_o, 32'hA0 + k);
      chk("burst_we", 32'(s_we_o), 1);
      s_ack_i = 1;
      #1;
      chk("burst_ack", 32'(m_ack_o), 32'b010);
      @(negedge clk);
      s_ack_i = 0;
      m_stb_i[1] = 0;
      if (k == 2) m_cyc_i[1] = 0;
      #1;
      chk("burst_stb_low", 32'(s_stb_o), 0);
      if (k < 2) begin
        @(negedge clk);
        #1;
        chk("burst_hold", 32'(grant_o), 32'b010);
        dat[1] = 32'hA1 + k;
        m_stb_i[1] = 1;
      end
    end
    m_we_i[1] = 0;
    mptr = 2;
    serve(0, 32'h55, 1);
    // reset while busy with the slave pending; a late ack must be ignored
    @(negedge clk);
    m_cyc_i[0] = 1;
    m_stb_i[0] = 1;
    @(negedge clk);
    #1;
    chk("pre_rst_grant", 32'(grant_o), 32'b001);
    rst_n = 0;
    @(negedge clk);
    #1;
    chk("mid_rst_cyc", 32'(s_cyc_o), 0);
    chk("mid_rst_grant", 32'(grant_o), 0);
    rst_n = 1;
    m_cyc_i[0] = 0;
    m_stb_i[0] = 0;
    s_ack_i = 1;
    #1;
    chk("late_ack", 32'(m_ack_o), 0);
    @(negedge clk);
    s_ack_i = 0;
    mptr = 0;
    // slave never acks master 2
    @(negedge clk);
    adr[2] = 30'h0000400;
    sel[2] = 4'h3;
    m_cyc_i[2] = 1;
    m_stb_i[2] = 1;
    @(negedge clk);
    #1;
    chk("to_grant", 32'(grant_o), 32'b100);
`ifdef MEMARB_TIMEOUT_EN
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) begin
        @(negedge clk);
        #1;
      end
      chk("to_ack", 32'(m_ack_o), k == 8 ? 32'b100 : 32'b0);
    end
    chk("to_dat", m_dat_o, 32'hFFFFFFFF);
    chk("to_stb", 32'(s_stb_o), 0);
    @(negedge clk);
    m_cyc_i[2] = 0;
    m_stb_i[2] = 0;
    #1;
    chk("to_flag", 32'(timeout_o), 1);
    repeat (3) @(negedge clk);
    #1;
    chk("to_sticky", 32'(timeout_o), 1);
`else
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) begin
        @(negedge clk);
        #1;
      end
      chk("no_to_ack", 32'(m_ack_o), 0);
    end
    chk("no_to_flag", 32'(timeout_o), 0);
    @(negedge clk);
    m_cyc_i[2] = 0;
    m_stb_i[2] = 0;
`endif
    mptr = 0;
    // random request sets served in round-robin order from the model pointer
    for (int r = 0; r < 25; r++) begin
      rq = NM'($urandom_range(1, (1 << NM) - 1));
      @(negedge clk);
      for (int i = 0; i < NM; i++)
        if (rq[i]) begin
          adr[i] = 30'($urandom);
          dat[i] = $urandom;
          sel[i] = 4'($urandom);
          m_we_i[i] = 1'($urandom);
          m_cyc_i[i] = 1;
          m_stb_i[i] = 1;
        end
      #1;
      while (rq != 0) begin
        m = mptr;
        while (!rq[m]) m = (m + 1) % NM;
        serve(m, $urandom, $urandom_range(0, 3));
        rq[m] = 0;
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wb_mem_arbiter.md
Name: wb_mem_arbiter

Overview:
- Shares the single 32-bit Wishbone port of the DDR2 memory wrapper between NM Wishbone masters, e.g. CPU, video fetch and DMA.
- Round-robin arbitration; a grant is held for the whole Wishbone cycle (cyc), so block/locked sequences are atomic.
- Sits in the cpu_clk domain, between the masters and the memory wrapper slave port.

Parameters:
- NM, 2, number of masters (2..8).
- TIMEOUT, 1023, cycles of unacknowledged stb before the watchdog fires (only used with MEMARB_TIMEOUT_EN).
- TW, 10, width of the timeout counter; must satisfy 2**TW > TIMEOUT.

Ports:
- cpu_clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low, sampled on cpu_clk.
- m_cyc_i  in  NM  per-master cyc; bit i = master i.
- m_stb_i  in  NM  per-master stb.
- m_we_i  in  NM  per-master we.
- m_adr_i  in  NM*30  master i occupies bits [i*30 +: 30]; each slice maps to adr[2:31].
- m_dat_i  in  NM*32  master i write data, slice [i*32 +: 32] = dat[0:31].
- m_sel_i  in  NM*4  master i byte selects, sel[0:3].
- m_dat_o  out  32  read data, broadcast to all masters.
- m_ack_o  out  NM  per-master ack.
- s_cyc_o, s_stb_o, s_we_o  out  1 each  to slave.
- s_adr_o  out  [2:31]  to slave.
- s_dat_o  out  [0:31]  to slave.
- s_sel_o  out  [0:3]  to slave.
- s_dat_i  in  [0:31]  from slave.
- s_ack_i  in  1  from slave.
- grant_o  out  NM  one-hot current grant, for debug/LEDs.
- timeout_o  out  1  sticky watchdog flag.

Behaviour:
- Reset (rst_n low at a clock edge):
  - state=IDLE, grant_o=0, rr pointer=0, timeout counter=0, timeout_o=0.
  - All m_ack_o and s_cyc_o/s_stb_o are 0 while no grant is held.
- States: IDLE, BUSY.
- IDLE:
  - If any m_cyc_i&m_stb_i is set, pick the first requester at or after the rr pointer, searching upward with wrap from NM-1 to 0.
  - Register the one-hot grant and go to BUSY.
  - Arbitration latency: request at edge n, slave sees s_cyc/s_stb from cycle n+1.
- BUSY:
  - s_cyc_o = m_cyc_i[g]; s_stb_o = m_stb_i[g].
  - we/adr/dat/sel are a combinational mux of master g.
  - m_ack_o[g] = s_ack_i & m_cyc_i[g] & m_stb_i[g]; other m_ack_o bits = 0.
  - m_dat_o = s_dat_i.
  - When m_cyc_i[g] is sampled low: grant cleared, rr pointer = (g+1) mod NM, return to IDLE.
  - Bus is idle for at least one cycle between grants; a new grant can be issued on the following edge.
- Simultaneous requests: the rr order decides. With NM=2 and both requesting continuously, grants alternate per cycle-transaction.
- Ungranted masters see no ack and wait. Their stb is never forwarded.
- A master dropping stb but keeping cyc keeps the grant (locked sequence).
- Slave ack arriving while no grant is held is ignored.
- Reset mid-transaction drops s_cyc_o immediately after the edge.
  - Any in-flight slave completion arriving later is ignored per the rule above.
  - The slave still completes its internal operation.

Optional Feature:
- Macro MEMARB_TIMEOUT_EN.
- Defined:
  - Counter increments each BUSY cycle with s_stb_o=1 and s_ack_i=0; it clears on ack or when leaving BUSY.
  - When the counter reaches TIMEOUT, the arbiter asserts m_ack_o[g] for one cycle with m_dat_o=32'hFFFFFFFF.
  - It forces s_stb_o=0 for that cycle, sets timeout_o (sticky until reset) and clears the counter.
- Not defined: no counter logic; timeout_o tied 0.

Decomposition:
- Package mem_arb_pkg:
  - state encoding constants ST_IDLE=1'b0, ST_BUSY=1'b1.
  - ADR_W=30, DAT_W=32, SEL_W=4.
  - TIMEOUT_DATA=32'hFFFFFFFF.
- Sub-module rr_pick:
  - Combinational round-robin picker.
  - Inputs: req[NM], ptr[clog2(NM)]. Output: one-hot gnt[NM]. gnt=0 when req=0.
  - Reusable for other shared resources.

Test Plan:
- Single master 0 read, adr=30'h0000100, slave acks after 5 cycles with 32'h12345678 -> s_stb rises 1 cycle after request; m_ack_o=2'b01 for one cycle; m_dat_o=32'h12345678.
- Masters 0 and 1 request in the same cycle from reset -> master 0 is granted first; after its cyc drops, master 1 is granted; the next simultaneous request goes to master 0 again (pointer wraps).
- Master 1 holds cyc across 3 writes (sel=4'b1111, data 32'hA0,A1,A2) while master 0 requests continuously -> all 3 writes complete to the slave before grant_o changes to 2'b01.
- rst_n low for 1 cycle while BUSY with the slave pending -> s_cyc_o=0 next cycle, grant_o=0; a late s_ack_i produces no m_ack_o.
- With MEMARB_TIMEOUT_EN and TIMEOUT=8, slave never acks -> m_ack_o[g] pulses on the 8th stalled cycle with m_dat_o=32'hFFFFFFFF; timeout_o=1 and stays 1.
- Without the macro, the same stimulus -> no ack ever; timeout_o=0.
